fx3_slave_fifo_model: RTL and testbench



---
 rtl/fx3_slave_fifo_model_pkg.sv | 19 +
 rtl/fx3_slave_fifo_model_fifo.sv | 64 ++++++
 rtl/fx3_slave_fifo_model.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_fx3_slave_fifo_model.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx3_slave_fifo_model_pkg.sv
// fx3_model_pkg
// Shared constants and types for the FX3 slave-FIFO responder model.
//   ADDR_WR / ADDR_RD : socket select codes on ez_usb_addr
//   DQ_W              : GPIF data bus width
//   FLAG_LAT_DEFAULT  : default strobe-to-flag latency in clocks
//   eg_entry_t        : egress FIFO entry {last, data}
package fx3_model_pkg;

   localparam logic [1:0]  ADDR_WR          = 2'b00;
   localparam logic [1:0]  ADDR_RD          = 2'b11;
   localparam int unsigned DQ_W             = 32;
   localparam int unsigned FLAG_LAT_DEFAULT = 3;

   typedef struct packed {
      logic            last;
      logic [DQ_W-1:0] data;
   } eg_entry_t;

endpackage

// File: rtl/fx3_slave_fifo_model_fifo.sv
// fx3_sync_fifo
// Single-clock first-word-fall-through FIFO with occupancy count.
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : write i_din (ignored when full unless popping the same cycle)
//   i_pop     : drop head word (ignored when empty)
//   o_dout    : current head word, valid while o_empty = 0
//   o_empty   : no words stored
//   o_count   : number of words stored, 0..DEPTH
module fx3_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_din,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_dout,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~w_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
      end
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/fx3_slave_fifo_model.sv
// fx3_slave_fifo_model
// Device-side responder for the FX3 GPIF II synchronous slave-FIFO bus.
// Write socket (addr 00): FPGA words are staged one deep, then committed into
// an egress FIFO as packets that leave on m_axis. Read socket (addr 11): host
// words arrive on s_axis and are returned to the FPGA on ez_usb_dout with a
// 2-cycle read latency. Flags are delayed FLAG_LAT cycles like the real part.
//   clk, rst            : clock, synchronous active-high reset
//   ez_usb_reset_n      : device reset, active low, combined with rst
//   ez_usb_addr         : socket select
//   ez_usb_din/dout     : data from / to FPGA; ez_usb_dout_t = FPGA tristate
//   ez_usb_sl*_n        : active-low chip select, write, read, OE, pktend
//   ez_usb_flaga..d     : wr not full, wr free >= WM, rd not empty, rd >= WM
//   s_axis_*            : host data into the read socket
//   m_axis_*            : committed packets out of the write socket
//   err_*               : sticky protocol error flags
//   zlp_count           : zero-length packet counter
module fx3_slave_fifo_model
   import fx3_model_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned PKT_WORDS = 256,
   parameter int unsigned WM        = 128,
   parameter int unsigned FLAG_LAT  = FLAG_LAT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ez_usb_reset_n,
   input  logic [1:0]      ez_usb_addr,
   input  logic [DQ_W-1:0] ez_usb_din,
   input  logic            ez_usb_dout_t,
   output logic [DQ_W-1:0] ez_usb_dout,
   input  logic            ez_usb_slcs_n,
   input  logic            ez_usb_slwr_n,
   input  logic            ez_usb_slrd_n,
   input  logic            ez_usb_sloe_n,
   input  logic            ez_usb_pktend_n,
   output logic            ez_usb_flaga,
   output logic            ez_usb_flagb,
   output logic            ez_usb_flagc,
   output logic            ez_usb_flagd,
   input  logic [DQ_W-1:0] s_axis_tdata,
   input  logic            s_axis_tvalid,
   output logic            s_axis_tready,
   output logic [DQ_W-1:0] m_axis_tdata,
   output logic            m_axis_tvalid,
   output logic            m_axis_tlast,
   input  logic            m_axis_tready,
   output logic            err_overflow,
   output logic            err_underflow,
   output logic            err_conflict,
   output logic [15:0]     zlp_count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned OW = CW + 1;
   localparam int unsigned PW = $clog2(PKT_WORDS) + 1;

   // ---------------------------------------------------------------- decode
   logic w_rst;
   logic w_cs;
   logic w_addr_wr;
   logic w_addr_rd;
   logic w_any_strobe;
   logic w_wr_req;
   logic w_pe_req;
   logic w_rd_req;

   assign w_rst        = rst | ~ez_usb_reset_n;
   assign w_cs         = ~ez_usb_slcs_n;
   assign w_addr_wr    = (ez_usb_addr == ADDR_WR);
   assign w_addr_rd    = (ez_usb_addr == ADDR_RD);
   assign w_any_strobe = ~ez_usb_slwr_n | ~ez_usb_slrd_n | ~ez_usb_sloe_n | ~ez_usb_pktend_n;
   assign w_wr_req     = w_cs & ~ez_usb_slwr_n   & w_addr_wr;
   assign w_pe_req     = w_cs & ~ez_usb_pktend_n & w_addr_wr;
   assign w_rd_req     = w_cs & ~ez_usb_slrd_n   & w_addr_rd;

   // ------------------------------------------------------- write socket
   logic            r_stg_valid;
   logic            r_stg_last;
   logic [DQ_W-1:0] r_stg_data;
   logic [PW-1:0]   r_pkt_cnt;
   logic [15:0]     r_zlp_cnt;

   eg_entry_t       w_eg_din;
   eg_entry_t       w_eg_head;
   logic            w_eg_push;
   logic            w_eg_empty;
   logic [CW-1:0]   w_eg_cnt;
   logic            w_m_pop;

   logic [CW-1:0]   w_wr_occ;
   logic            w_wr_full;
   logic            w_wr_ok;
   logic            w_wr_drop;
   logic            w_pe_alone;
   logic            w_pkt_empty;
   logic            w_pe_commit;
   logic            w_zlp;
   logic [PW-1:0]   w_pkt_cnt_inc;
   logic            w_wr_last;
   logic [OW-1:0]   w_wr_occ_next;

   // Occupancy seen by the FPGA includes the staged word.
   assign w_wr_occ      = w_eg_cnt + CW'(r_stg_valid);
   assign w_wr_full     = (w_wr_occ == CW'(DEPTH));
   assign w_wr_ok       = w_wr_req & ~w_wr_full;
   assign w_wr_drop     = w_wr_req & w_wr_full;
   // A dropped write leaves any pktend on that cycle acting on its own.
   assign w_pe_alone    = w_pe_req & ~w_wr_ok;
   assign w_pkt_empty   = (r_pkt_cnt == '0);
   assign w_pe_commit   = w_pe_alone & ~w_pkt_empty;
   assign w_zlp         = w_pe_alone &  w_pkt_empty;
   assign w_pkt_cnt_inc = r_pkt_cnt + PW'(1);
   assign w_wr_last     = w_pe_req | (w_pkt_cnt_inc == PW'(PKT_WORDS));

   // The staged word leaves when it is already marked last, when a newer word
   // displaces it, or when a lone pktend closes the packet around it. A
   // non-zero packet count guarantees the staging register holds a word.
   assign w_eg_push     = r_stg_valid & (r_stg_last | w_wr_ok | w_pe_commit);
   assign w_eg_din.last = r_stg_last | w_pe_commit;
   assign w_eg_din.data = r_stg_data;

   assign w_m_pop       = m_axis_tready & ~w_eg_empty;

   // Moving the staged word into the FIFO does not change total occupancy.
   assign w_wr_occ_next = OW'(w_wr_occ) + OW'(w_wr_ok) - OW'(w_m_pop);

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_stg_valid <= 1'b0;
         r_stg_last  <= 1'b0;
         r_stg_data  <= '0;
         r_pkt_cnt   <= '0;
      end else if (w_wr_ok) begin
         r_stg_valid <= 1'b1;
         r_stg_last  <= w_wr_last;
         r_stg_data  <= ez_usb_din;
         r_pkt_cnt   <= w_wr_last ? '0 : w_pkt_cnt_inc;
      end else begin
         if (w_eg_push) begin
            r_stg_valid <= 1'b0;
            r_stg_last  <= 1'b0;
         end
         if (w_pe_commit) begin
            r_pkt_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_zlp_cnt <= '0;
      end else if (w_zlp) begin
         r_zlp_cnt <= r_zlp_cnt + 16'd1;
      end
   end

   fx3_sync_fifo #(
      .WIDTH ($bits(eg_entry_t)),
      .DEPTH (DEPTH)
   ) u_egress (
      .clk     (clk),
      .rst     (w_rst),
      .i_push  (w_eg_push),
      .i_din   (w_eg_din),
      .i_pop   (w_m_pop),
      .o_dout  (w_eg_head),
      .o_empty (w_eg_empty),
      .o_count (w_eg_cnt)
   );

   // -------------------------------------------------------- read socket
   logic            r_s_tready;
   logic            w_s_push;
   logic [DQ_W-1:0] w_rd_head;
   logic            w_rd_empty;
   logic [CW-1:0]   w_rd_cnt;
   logic            w_rd_pop_ok;
   logic [OW-1:0]   w_rd_occ_next;

   assign w_s_push      = s_axis_tvalid & r_s_tready;
   assign w_rd_pop_ok   = w_rd_req & ~w_rd_empty;
   assign w_rd_occ_next = OW'(w_rd_cnt) + OW'(w_s_push) - OW'(w_rd_pop_ok);

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_s_tready <= 1'b0;
      end else begin
         r_s_tready <= (w_rd_occ_next != OW'(DEPTH));
      end
   end

   fx3_sync_fifo #(
      .WIDTH (DQ_W),
      .DEPTH (DEPTH)
   ) u_ingress (
      .clk     (clk),
      .rst     (w_rst),
      .i_push  (w_s_push),
      .i_din   (s_axis_tdata),
      .i_pop   (w_rd_req),
      .o_dout  (w_rd_head),
      .o_empty (w_rd_empty),
      .o_count (w_rd_cnt)
   );

   // Two pipeline stages after the pop, then a hold register that keeps the
   // last returned word on the bus until the next one lands.
   logic            r_p1_vld;
   logic [DQ_W-1:0] r_p1_data;
   logic            r_p2_vld;
   logic [DQ_W-1:0] r_p2_data;
   logic [DQ_W-1:0] r_dout;

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_p1_vld  <= 1'b0;
         r_p1_data <= '0;
         r_p2_vld  <= 1'b0;
         r_p2_data <= '0;
         r_dout    <= '0;
      end else begin
         r_p1_vld  <= w_rd_req;
         r_p1_data <= w_rd_empty ? '0 : w_rd_head;
         r_p2_vld  <= r_p1_vld;
         r_p2_data <= r_p1_data;
         if (r_p2_vld) begin
            r_dout <= r_p2_data;
         end
      end
   end

   // -------------------------------------------------------------- flags
   // Bit order {d, c, b, a}; raw flags come from post-update occupancy.
   logic [3:0] w_flag_raw;
   logic [3:0] r_flag_dly [FLAG_LAT];

   assign w_flag_raw[0] = (w_wr_occ_next != OW'(DEPTH));
   assign w_flag_raw[1] = ((OW'(DEPTH) - w_wr_occ_next) >= OW'(WM));
   assign w_flag_raw[2] = (w_rd_occ_next != '0);
   assign w_flag_raw[3] = (w_rd_occ_next >= OW'(WM));

   always_ff @(posedge clk) begin
      if (w_rst) begin
         for (int unsigned i = 0; i < FLAG_LAT; i++) begin
            r_flag_dly[i] <= 4'b0011;
         end
      end else begin
         r_flag_dly[0] <= w_flag_raw;
         for (int unsigned i = 1; i < FLAG_LAT; i++) begin
            r_flag_dly[i] <= r_flag_dly[i-1];
         end
      end
   end

   // ------------------------------------------------------------- errors
   logic r_err_ovf;
   logic r_err_udf;
   logic r_err_cfl;
   logic w_conflict;

   assign w_conflict = w_cs & ((w_any_strobe & ~(w_addr_wr | w_addr_rd)) |
                               (~ez_usb_sloe_n & ~ez_usb_dout_t) |
                               (~ez_usb_slwr_n &  ez_usb_dout_t));

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_err_ovf <= 1'b0;
         r_err_udf <= 1'b0;
         r_err_cfl <= 1'b0;
      end else begin
         if (w_wr_drop) begin
            r_err_ovf <= 1'b1;
         end
         if (w_rd_req & w_rd_empty) begin
            r_err_udf <= 1'b1;
         end
         if (w_conflict) begin
            r_err_cfl <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------ outputs
   assign ez_usb_dout   = (w_cs & ~ez_usb_sloe_n) ? r_dout : '0;
   assign ez_usb_flaga  = r_flag_dly[FLAG_LAT-1][0];
   assign ez_usb_flagb  = r_flag_dly[FLAG_LAT-1][1];
   assign ez_usb_flagc  = r_flag_dly[FLAG_LAT-1][2];
   assign ez_usb_flagd  = r_flag_dly[FLAG_LAT-1][3];
   assign s_axis_tready = r_s_tready;
   assign m_axis_tvalid = ~w_eg_empty;
   assign m_axis_tdata  = w_eg_empty ? '0 : w_eg_head.data;
   assign m_axis_tlast  = ~w_eg_empty & w_eg_head.last;
   assign err_overflow  = r_err_ovf;
   assign err_underflow = r_err_udf;
   assign err_conflict  = r_err_cfl;
   assign zlp_count     = r_zlp_cnt;

endmodule

// File: tb/tb_fx3_slave_fifo_model.sv
// tb_fx3_slave_fifo_model
// Directed self-checking bench for fx3_slave_fifo_model at default parameters.
module tb_fx3_slave_fifo_model;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned PKT   = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        ez_usb_reset_n;
   logic [1:0]  ez_usb_addr;
   logic [31:0] ez_usb_din;
   logic        ez_usb_dout_t;
   logic [31:0] ez_usb_dout;
   logic        ez_usb_slcs_n;
   logic        ez_usb_slwr_n;
   logic        ez_usb_slrd_n;
   logic        ez_usb_sloe_n;
   logic        ez_usb_pktend_n;
   logic        ez_usb_flaga;
   logic        ez_usb_flagb;
   logic        ez_usb_flagc;
   logic        ez_usb_flagd;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic        err_overflow;
   logic        err_underflow;
   logic        err_conflict;
   logic [15:0] zlp_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fx3_slave_fifo_model #(
      .DEPTH     (DEPTH),
      .PKT_WORDS (PKT),
      .WM        (128),
      .FLAG_LAT  (3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ez_usb_reset_n  (ez_usb_reset_n),
      .ez_usb_addr     (ez_usb_addr),
      .ez_usb_din      (ez_usb_din),
      .ez_usb_dout_t   (ez_usb_dout_t),
      .ez_usb_dout     (ez_usb_dout),
      .ez_usb_slcs_n   (ez_usb_slcs_n),
      .ez_usb_slwr_n   (ez_usb_slwr_n),
      .ez_usb_slrd_n   (ez_usb_slrd_n),
      .ez_usb_sloe_n   (ez_usb_sloe_n),
      .ez_usb_pktend_n (ez_usb_pktend_n),
      .ez_usb_flaga    (ez_usb_flaga),
      .ez_usb_flagb    (ez_usb_flagb),
      .ez_usb_flagc    (ez_usb_flagc),
      .ez_usb_flagd    (ez_usb_flagd),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tready   (m_axis_tready),
      .err_overflow    (err_overflow),
      .err_underflow   (err_underflow),
      .err_conflict    (err_conflict),
      .zlp_count       (zlp_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      ez_usb_slcs_n   = 1'b1;
      ez_usb_addr     = 2'b00;
      ez_usb_slwr_n   = 1'b1;
      ez_usb_slrd_n   = 1'b1;
      ez_usb_sloe_n   = 1'b1;
      ez_usb_pktend_n = 1'b1;
      ez_usb_dout_t   = 1'b1;
   endtask

   task automatic fpga_write(input logic [31:0] d, input logic pe);
      ez_usb_slcs_n   = 1'b0;
      ez_usb_addr     = 2'b00;
      ez_usb_dout_t   = 1'b0;
      ez_usb_sloe_n   = 1'b1;
      ez_usb_din      = d;
      ez_usb_slwr_n   = 1'b0;
      ez_usb_pktend_n = ~pe;
      tick();
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_dout"},   ez_usb_dout,   32'h0);
      check({pfx, "_flaga"},  ez_usb_flaga,  1);
      check({pfx, "_flagb"},  ez_usb_flagb,  1);
      check({pfx, "_flagc"},  ez_usb_flagc,  0);
      check({pfx, "_flagd"},  ez_usb_flagd,  0);
      check({pfx, "_tready"}, s_axis_tready, 0);
      check({pfx, "_tvalid"}, m_axis_tvalid, 0);
      check({pfx, "_tlast"},  m_axis_tlast,  0);
      check({pfx, "_ovf"},    err_overflow,  0);
      check({pfx, "_udf"},    err_underflow, 0);
      check({pfx, "_cfl"},    err_conflict,  0);
      check({pfx, "_zlp"},    zlp_count,     0);
   endtask

   // Pulls n beats off m_axis; tlast expected at every pkt-th word and on the final word.
   task automatic drain(input string tag, input int n, input logic [31:0] base, input int pkt);
      m_axis_tready = 1'b1;
      for (int i = 0; i < n; i++) begin
         check({tag, "_tvalid"}, m_axis_tvalid, 1);
         check({tag, "_tdata"},  m_axis_tdata,  base + 32'(i));
         check({tag, "_tlast"},  m_axis_tlast,  ((((i + 1) % pkt) == 0) || (i == n - 1)) ? 1 : 0);
         tick();
      end
      m_axis_tready = 1'b0;
      check({tag, "_empty"}, m_axis_tvalid, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst            = 1'b1;
      ez_usb_reset_n = 1'b1;
      ez_usb_din     = '0;
      s_axis_tdata   = '0;
      s_axis_tvalid  = 1'b0;
      m_axis_tready  = 1'b0;
      bus_idle();

      // Reset state
      tick(); tick(); tick();
      check_reset_values("rst");
      rst = 1'b0;
      tick();
      check("tready_after_rst", s_axis_tready, 1);

      // Short packet: 5 words, pktend with the 5th
      for (int i = 0; i < 5; i++) fpga_write(32'h1000_0000 + 32'(i), (i == 4));
      bus_idle();
      tick(); tick();
      drain("short", 5, 32'h1000_0000, 1000);
      check("short_zlp", zlp_count, 0);

      // Full packet by count, then a 2-word short packet
      for (int i = 0; i < 258; i++) fpga_write(32'h3000_0000 + 32'(i), (i == 257));
      bus_idle();
      tick(); tick();
      drain("full", 258, 32'h3000_0000, PKT);

      // Zero-length packet
      ez_usb_slcs_n   = 1'b0;
      ez_usb_pktend_n = 1'b0;
      tick();
      bus_idle();
      tick(); tick();
      check("zlp_count", zlp_count, 1);
      check("zlp_no_beat", m_axis_tvalid, 0);

      // Overflow with m_axis stalled
      for (int i = 0; i < DEPTH - 1; i++) fpga_write(32'h2000_0000 + 32'(i), 1'b0);
      fpga_write(32'h2000_0000 + 32'(DEPTH - 1), 1'b0);
      check("flaga_lat1", ez_usb_flaga, 1);
      fpga_write(32'hDEAD_BEEF, 1'b0);
      bus_idle();
      check("flaga_lat2", ez_usb_flaga, 1);
      check("err_overflow", err_overflow, 1);
      tick();
      check("flaga_lat3", ez_usb_flaga, 0);
      check("flagb_full", ez_usb_flagb, 0);
      tick();
      drain("ovf", DEPTH, 32'h2000_0000, PKT);

      // Host pushes three words
      check("flagc_idle", ez_usb_flagc, 0);
      s_axis_tvalid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         s_axis_tdata = 32'hA5A5_0000 + 32'(i);
         tick();
      end
      s_axis_tvalid = 1'b0;

      // Three back-to-back reads with OE on
      ez_usb_slcs_n = 1'b0;
      ez_usb_addr   = 2'b11;
      ez_usb_dout_t = 1'b1;
      ez_usb_sloe_n = 1'b0;
      ez_usb_slrd_n = 1'b0;
      tick();
      check("rd_lat1", ez_usb_dout, 32'h0);
      tick();
      check("rd_lat2", ez_usb_dout, 32'h0);
      tick();
      ez_usb_slrd_n = 1'b1;
      check("rd_word1", ez_usb_dout, 32'hA5A5_0001);
      check("flagc_lat1", ez_usb_flagc, 1);
      tick();
      check("rd_word2", ez_usb_dout, 32'hA5A5_0002);
      check("flagc_lat2", ez_usb_flagc, 1);
      tick();
      check("rd_word3", ez_usb_dout, 32'hA5A5_0003);
      check("flagc_lat3", ez_usb_flagc, 0);
      tick();
      check("rd_hold", ez_usb_dout, 32'hA5A5_0003);
      ez_usb_sloe_n = 1'b1;
      #1;
      check("oe_gate", ez_usb_dout, 32'h0);
      ez_usb_sloe_n = 1'b0;
      #1;

      // Underflow
      ez_usb_slrd_n = 1'b0;
      tick();
      ez_usb_slrd_n = 1'b1;
      check("err_underflow", err_underflow, 1);
      tick();
      check("udf_hold", ez_usb_dout, 32'hA5A5_0003);
      tick();
      check("udf_dout", ez_usb_dout, 32'h0);
      check("no_conflict", err_conflict, 0);

      // Illegal address with an active strobe
      ez_usb_addr   = 2'b01;
      ez_usb_sloe_n = 1'b1;
      ez_usb_dout_t = 1'b0;
      ez_usb_slwr_n = 1'b0;
      tick();
      bus_idle();
      check("err_conflict", err_conflict, 1);

      // Mid-packet reset with data in every path
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h5A5A_0007;
      tick();
      s_axis_tvalid = 1'b0;
      ez_usb_slcs_n = 1'b0;
      ez_usb_addr   = 2'b11;
      ez_usb_slrd_n = 1'b0;
      tick();
      ez_usb_slrd_n = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h5A5A_0008;
      tick();
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < 3; i++) fpga_write(32'h4000_0000 + 32'(i), 1'b0);
      bus_idle();
      ez_usb_slcs_n = 1'b0;
      ez_usb_addr   = 2'b11;
      ez_usb_sloe_n = 1'b0;
      tick();
      check("pre_rst_dout", ez_usb_dout, 32'h5A5A_0007);
      check("pre_rst_flagc", ez_usb_flagc, 1);
      check("pre_rst_tvalid", m_axis_tvalid, 1);
      rst = 1'b1;
      tick();
      check_reset_values("midrst");
      rst = 1'b0;
      bus_idle();
      tick();
      check("tready_after_midrst", s_axis_tready, 1);

      // Staging and packet count were discarded: a lone pktend is a ZLP
      ez_usb_slcs_n   = 1'b0;
      ez_usb_pktend_n = 1'b0;
      tick();
      bus_idle();
      tick(); tick();
      check("post_rst_zlp", zlp_count, 1);
      check("post_rst_no_beat", m_axis_tvalid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
